// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared types and constants for the blink monitor
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        TIMEOUT
    } blink_state_e;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchronizer for asynchronous pad inputs
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/blink_monitor.sv
// rtl/blink_monitor.sv - measures half-periods of an asynchronous square wave
module blink_monitor
    import blink_pkg::*;
#(
    parameter  int COUNT       = 1000000,
    parameter  int SYNC_STAGES = 2,
    localparam int W           = $clog2(COUNT + 1)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         sig_i,
    output logic [W-1:0] halfper_o,
    output logic         level_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic         timeout_o,
    output logic         overrun_o
);

    localparam logic [W-1:0] CNT_MAX = W'(COUNT);

    generate
        if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
            $error("blink_monitor: SYNC_STAGES out of range");
        end
    endgenerate

    logic         s;
    logic         s_prev;
    logic         edge_det;
    logic         at_max;
    logic         emit;
    logic [W-1:0] cnt;
    blink_state_e state;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .d     (sig_i),
        .q     (s)
    );

    assign edge_det = s ^ s_prev;
    assign at_max   = (cnt == CNT_MAX);
    assign emit     = (state == MEASURE) && edge_det;

    // Counter saturates at COUNT so a stuck input never wraps into a bogus short period.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_prev <= 1'b0;
            cnt    <= '0;
        end else begin
            s_prev <= s;
            if (edge_det) begin
                cnt <= W'(1);
            end else if (!at_max) begin
                cnt <= cnt + W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            timeout_o <= 1'b0;
            halfper_o <= '0;
            level_o   <= 1'b0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            case (state)
                IDLE, MEASURE: begin
                    if (edge_det) begin
                        state <= MEASURE;
                    end else if (at_max) begin
                        state     <= TIMEOUT;
                        timeout_o <= 1'b1;
                    end
                end
                TIMEOUT: begin
                    if (edge_det) begin
                        state     <= MEASURE;
                        timeout_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    timeout_o <= 1'b0;
                end
            endcase

            // Single-entry holding register; a drain in the same cycle frees it for the new value.
            if (emit) begin
                if (!valid_o || ready_i) begin
                    halfper_o <= cnt;
                    level_o   <= s_prev;
                    valid_o   <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blink_monitor.sv
// tb/tb_blink_monitor.sv - directed self-checking bench for blink_monitor
module tb_blink_monitor;

    localparam int COUNT = 16;
    localparam int SYNC  = 2;
    localparam int W     = 5;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic         sig_i;
    logic         ready_i;
    logic [W-1:0] halfper_o;
    logic         level_o;
    logic         valid_o;
    logic         timeout_o;
    logic         overrun_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    blink_monitor #(.COUNT(COUNT), .SYNC_STAGES(SYNC)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .sig_i     (sig_i),
        .halfper_o (halfper_o),
        .level_o   (level_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .timeout_o (timeout_o),
        .overrun_o (overrun_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic rdy);
        rst_ni  = 1'b0;
        sig_i   = 1'b0;
        ready_i = rdy;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    function automatic logic wave_level(input int t, input int hi, input int lo);
        if (t < 0) return 1'b0;
        return (t % (hi + lo)) < hi;
    endfunction

    task automatic test_reset();
        rst_ni  = 1'b0;
        sig_i   = 1'b0;
        ready_i = 1'b0;
        tick();
        n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", valid_o); end
        n_cmp++; if (halfper_o !== 5'd0) begin n_fail++; $display("FAIL reset_halfper: got %0d expected 0", halfper_o); end
        n_cmp++; if (level_o !== 1'b0) begin n_fail++; $display("FAIL reset_level: got %0b expected 0", level_o); end
        n_cmp++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %0b expected 0", timeout_o); end
        n_cmp++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %0b expected 0", overrun_o); end
    endtask

    // Emits appear 3 sample cycles after the toggle cycle; the toggle at t=0 is the IDLE edge.
    task automatic test_wave(input int hi, input int lo, input int n);
        logic         exp_v;
        logic         exp_l;
        logic [W-1:0] exp_h;
        start(1'b1);
        for (int t = 0; t < n; t++) begin
            exp_v = (t >= 4) && (wave_level(t - 3, hi, lo) != wave_level(t - 4, hi, lo));
            exp_l = wave_level(t - 4, hi, lo);
            exp_h = exp_l ? W'(hi) : W'(lo);
            n_cmp++; if (valid_o !== exp_v) begin n_fail++; $display("FAIL wave%0d_%0d_valid t=%0d: got %0b expected %0b", hi, lo, t, valid_o, exp_v); end
            if (exp_v) begin
                n_cmp++; if (halfper_o !== exp_h) begin n_fail++; $display("FAIL wave%0d_%0d_halfper t=%0d: got %0d expected %0d", hi, lo, t, halfper_o, exp_h); end
                n_cmp++; if (level_o !== exp_l) begin n_fail++; $display("FAIL wave%0d_%0d_level t=%0d: got %0b expected %0b", hi, lo, t, level_o, exp_l); end
            end
            sig_i = wave_level(t, hi, lo);
            tick();
        end
    endtask

    task automatic test_back_to_back();
        start(1'b1);
        for (int t = 0; t < 10; t++) begin
            if (t == 5) begin
                n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_valid5: got %0b expected 1", valid_o); end
                n_cmp++; if (halfper_o !== 5'd2) begin n_fail++; $display("FAIL b2b_halfper5: got %0d expected 2", halfper_o); end
                n_cmp++; if (level_o !== 1'b1) begin n_fail++; $display("FAIL b2b_level5: got %0b expected 1", level_o); end
            end
            if (t == 6) begin
                n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_valid6: got %0b expected 1", valid_o); end
                n_cmp++; if (halfper_o !== 5'd1) begin n_fail++; $display("FAIL b2b_halfper6: got %0d expected 1", halfper_o); end
                n_cmp++; if (level_o !== 1'b0) begin n_fail++; $display("FAIL b2b_level6: got %0b expected 0", level_o); end
            end
            if (t == 7) begin
                n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_valid7: got %0b expected 0", valid_o); end
            end
            sig_i = (t < 2 || t >= 3);
            tick();
        end
    endtask

    task automatic test_count_edge();
        start(1'b1);
        for (int t = 0; t < 22; t++) begin
            if (t >= 18 && t <= 20) begin
                n_cmp++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL cmax_timeout t=%0d: got %0b expected 0", t, timeout_o); end
            end
            if (t == 19) begin
                n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL cmax_valid: got %0b expected 1", valid_o); end
                n_cmp++; if (halfper_o !== 5'd16) begin n_fail++; $display("FAIL cmax_halfper: got %0d expected 16", halfper_o); end
                n_cmp++; if (level_o !== 1'b1) begin n_fail++; $display("FAIL cmax_level: got %0b expected 1", level_o); end
            end
            sig_i = (t < 16);
            tick();
        end
    endtask

    task automatic test_overrun();
        start(1'b0);
        for (int t = 0; t < 22; t++) begin
            if (t == 7) begin
                n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL ovr_valid7: got %0b expected 1", valid_o); end
                n_cmp++; if (halfper_o !== 5'd4) begin n_fail++; $display("FAIL ovr_halfper7: got %0d expected 4", halfper_o); end
                n_cmp++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL ovr_overrun7: got %0b expected 0", overrun_o); end
            end
            if (t == 11) begin
                n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL ovr_valid11: got %0b expected 1", valid_o); end
                n_cmp++; if (halfper_o !== 5'd4) begin n_fail++; $display("FAIL ovr_halfper11: got %0d expected 4", halfper_o); end
                n_cmp++; if (level_o !== 1'b1) begin n_fail++; $display("FAIL ovr_level11: got %0b expected 1", level_o); end
                n_cmp++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_overrun11: got %0b expected 1", overrun_o); end
            end
            if (t == 13) begin
                n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL ovr_valid13: got %0b expected 0", valid_o); end
                n_cmp++; if (halfper_o !== 5'd4) begin n_fail++; $display("FAIL ovr_halfper13: got %0d expected 4", halfper_o); end
                n_cmp++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_overrun13: got %0b expected 1", overrun_o); end
            end
            if (t == 20) begin
                n_cmp++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_overrun20: got %0b expected 1", overrun_o); end
            end
            sig_i   = (t < 4) || (t >= 8);
            ready_i = (t == 12);
            tick();
        end
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL ovr_cleared_by_reset: got %0b expected 0", overrun_o); end
    endtask

    task automatic test_ready_on_emit();
        start(1'b0);
        for (int t = 0; t < 16; t++) begin
            if (t == 7) begin
                n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL roe_valid7: got %0b expected 1", valid_o); end
                n_cmp++; if (halfper_o !== 5'd4) begin n_fail++; $display("FAIL roe_halfper7: got %0d expected 4", halfper_o); end
            end
            if (t == 13 || t == 15) begin
                n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL roe_valid t=%0d: got %0b expected 1", t, valid_o); end
                n_cmp++; if (halfper_o !== 5'd6) begin n_fail++; $display("FAIL roe_halfper t=%0d: got %0d expected 6", t, halfper_o); end
                n_cmp++; if (level_o !== 1'b0) begin n_fail++; $display("FAIL roe_level t=%0d: got %0b expected 0", t, level_o); end
                n_cmp++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL roe_overrun t=%0d: got %0b expected 0", t, overrun_o); end
            end
            sig_i   = (t < 4) || (t >= 10);
            ready_i = (t == 12);
            tick();
        end
    endtask

    task automatic test_timeout();
        start(1'b1);
        for (int t = 0; t < 50; t++) begin
            if (t == 7 || t == 11) begin
                n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL to_valid t=%0d: got %0b expected 1", t, valid_o); end
                n_cmp++; if (halfper_o !== 5'd4) begin n_fail++; $display("FAIL to_halfper t=%0d: got %0d expected 4", t, halfper_o); end
            end
            if (t >= 12 && t <= 46) begin
                n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL to_noemit t=%0d: got %0b expected 0", t, valid_o); end
            end
            if (t == 26 || t == 41) begin
                n_cmp++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL to_timeout_low t=%0d: got %0b expected 0", t, timeout_o); end
            end
            if (t == 27 || t == 40) begin
                n_cmp++; if (timeout_o !== 1'b1) begin n_fail++; $display("FAIL to_timeout_high t=%0d: got %0b expected 1", t, timeout_o); end
            end
            if (t == 47) begin
                n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL to_valid47: got %0b expected 1", valid_o); end
                n_cmp++; if (halfper_o !== 5'd6) begin n_fail++; $display("FAIL to_halfper47: got %0d expected 6", halfper_o); end
                n_cmp++; if (level_o !== 1'b0) begin n_fail++; $display("FAIL to_level47: got %0b expected 0", level_o); end
            end
            sig_i = (t < 4) || (t >= 8 && t < 38) || (t >= 44);
            tick();
        end
    endtask

    task automatic test_reset_mid();
        start(1'b0);
        for (int t = 0; t < 10; t++) begin
            if (t == 8) begin
                n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL rm_valid8: got %0b expected 1", valid_o); end
                n_cmp++; if (halfper_o !== 5'd5) begin n_fail++; $display("FAIL rm_halfper8: got %0d expected 5", halfper_o); end
            end
            sig_i = (t < 5);
            tick();
        end
        #3;
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rm_async_valid: got %0b expected 0", valid_o); end
        n_cmp++; if (halfper_o !== 5'd0) begin n_fail++; $display("FAIL rm_async_halfper: got %0d expected 0", halfper_o); end
        n_cmp++; if (level_o !== 1'b0) begin n_fail++; $display("FAIL rm_async_level: got %0b expected 0", level_o); end
        n_cmp++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL rm_async_timeout: got %0b expected 0", timeout_o); end
        n_cmp++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL rm_async_overrun: got %0b expected 0", overrun_o); end
        tick();
        tick();
        rst_ni = 1'b1;
        for (int t = 0; t < 12; t++) begin
            if (t < 10) begin
                n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rm_post_noemit t=%0d: got %0b expected 0", t, valid_o); end
            end
            if (t == 10) begin
                n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL rm_post_valid10: got %0b expected 1", valid_o); end
                n_cmp++; if (halfper_o !== 5'd4) begin n_fail++; $display("FAIL rm_post_halfper10: got %0d expected 4", halfper_o); end
                n_cmp++; if (level_o !== 1'b1) begin n_fail++; $display("FAIL rm_post_level10: got %0b expected 1", level_o); end
            end
            sig_i = (t >= 3 && t < 7);
            tick();
        end
    endtask

    initial begin
        rst_ni  = 1'b0;
        sig_i   = 1'b0;
        ready_i = 1'b0;
        test_reset();
        test_wave(5, 5, 40);
        test_wave(3, 7, 40);
        test_back_to_back();
        test_count_edge();
        test_overrun();
        test_ready_on_emit();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
